// File: rtl/vmm_stream_engine.sv
`timescale 1ns/1ps
// Streaming L x M by M x N matrix multiplier: A/B held in local storage, each
// C element accumulated over M cycles and handed out over a valid/ready port.
module vmm_stream_engine #(
    parameter int L      = 4,
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int DW     = 4,
    parameter int ACC_W  = 12,
    parameter int SIGNED = 0,
    localparam int AMAX  = (L * M > M * N) ? L * M : M * N,
    localparam int AW    = (AMAX > 1) ? $clog2(AMAX) : 1,
    localparam int RW    = (L > 1) ? $clog2(L) : 1,
    localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             vmm_clk,
    input  logic             rst_,
    input  logic             load_en,
    input  logic             load_sel,
    input  logic [AW-1:0]    load_addr,
    input  logic [DW-1:0]    load_data,
    input  logic             start,
    input  logic             sat_en,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [RW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic             ovf,
    output logic [2:0]       state_dbg
);

    localparam int   KW  = (M > 1) ? $clog2(M) : 1;
    localparam int   AAW = (L * M > 1) ? $clog2(L * M) : 1;
    localparam int   BAW = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int   PX  = ACC_W + 1 - 2 * DW;
    localparam logic SX  = (SIGNED != 0);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        MAC  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [DW-1:0]    a_mem [L*M];
    logic [DW-1:0]    b_mem [M*N];
    logic [RW-1:0]    i;
    logic [CW-1:0]    j;
    logic [KW-1:0]    k;
    logic [ACC_W-1:0] acc, acc_nx;
    logic             sat_q;
    logic             ovf_q, ovf_now;

    logic [AAW-1:0]   a_idx;
    logic [BAW-1:0]   b_idx;
    logic [DW-1:0]    a_el, b_el;
    logic [2*DW-1:0]  a_x, b_x, prod;
    logic [ACC_W:0]   sum;
    logic             last_row, last_col, last_k;
    logic             a_ok, b_ok;

    assign a_ok = 32'(load_addr) < L * M;
    assign b_ok = 32'(load_addr) < M * N;

    // Storage has no reset: operands survive a reset and can be reused.
    always_ff @(posedge vmm_clk) begin
        if (state == IDLE && load_en) begin
            if (!load_sel && a_ok) a_mem[AAW'(load_addr)] <= load_data;
            if (load_sel && b_ok)  b_mem[BAW'(load_addr)] <= load_data;
        end
    end

    assign a_idx = AAW'(int'(i) * M + int'(k));
    assign b_idx = BAW'(int'(k) * N + int'(j));
    assign a_el  = a_mem[a_idx];
    assign b_el  = b_mem[b_idx];

    // Sum one bit wider than the accumulator so overflow is visible in the top bits.
    always_comb begin
        a_x     = {{DW{SX & a_el[DW-1]}}, a_el};
        b_x     = {{DW{SX & b_el[DW-1]}}, b_el};
        prod    = a_x * b_x;
        sum     = {SX & acc[ACC_W-1], acc} + {{PX{SX & prod[2*DW-1]}}, prod};
        ovf_now = SX ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
        acc_nx  = sum[ACC_W-1:0];
        if (ovf_now && sat_q) begin
            if (!SX)            acc_nx = '1;
            else if (sum[ACC_W]) acc_nx = {1'b1, {(ACC_W-1){1'b0}}};
            else                acc_nx = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    assign last_row = (i == RW'(L - 1));
    assign last_col = (j == CW'(N - 1));
    assign last_k   = (k == KW'(M - 1));

    // out_valid/out_ready: an element transfers on a rising edge where both are
    // high; while out_valid is high without out_ready, data/row/col stay frozen.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CLR;
            CLR:     state_nx = MAC;
            MAC:     if (last_k) state_nx = EMIT;
            EMIT:    if (out_ready) state_nx = (last_row && last_col) ? DONE : CLR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge vmm_clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (start) begin
                    sat_q <= sat_en;
                    ovf_q <= 1'b0;
                    i     <= '0;
                    j     <= '0;
                end
                CLR: begin
                    acc <= '0;
                    k   <= '0;
                end
                MAC: begin
                    acc <= acc_nx;
                    k   <= k + 1'b1;
                    if (ovf_now) ovf_q <= 1'b1;
                end
                EMIT: if (out_ready) begin
                    if (!last_col) begin
                        j <= j + 1'b1;
                    end else if (!last_row) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == CLR) || (state == MAC) || (state == EMIT);
    assign done      = (state == DONE);
    assign out_valid = (state == EMIT);
    assign out_data  = acc;
    assign out_row   = i;
    assign out_col   = j;
    assign ovf       = ovf_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_vmm_stream_engine.sv
`timescale 1ns/1ps
// Bench for vmm_stream_engine: an unsigned 2x2x2 instance and a signed 2x2x3
// instance share clock and reset; outputs are scored against expected queues.
module tb_vmm_stream_engine;

    localparam int EW = 12;

    logic vmm_clk = 1'b0;
    logic rst_    = 1'b0;
    always #5 vmm_clk = ~vmm_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] u_exp_q[$];
    logic [EW-1:0] s_exp_q[$];

    logic       u_load_en, u_load_sel, u_start, u_sat_en, u_out_ready;
    logic [1:0] u_load_addr;
    logic [3:0] u_load_data;
    logic       u_busy, u_done, u_out_valid, u_ovf;
    logic [7:0] u_out_data;
    logic       u_out_row, u_out_col;
    logic [2:0] u_state_dbg;

    logic       s_load_en, s_load_sel, s_start, s_sat_en, s_out_ready;
    logic [2:0] s_load_addr;
    logic [3:0] s_load_data;
    logic       s_busy, s_done, s_out_valid, s_ovf;
    logic [7:0] s_out_data;
    logic       s_out_row;
    logic [1:0] s_out_col;
    logic [2:0] s_state_dbg;

    vmm_stream_engine #(.L(2), .M(2), .N(2), .DW(4), .ACC_W(8), .SIGNED(0)) u_dut (
        .vmm_clk(vmm_clk), .rst_(rst_),
        .load_en(u_load_en), .load_sel(u_load_sel), .load_addr(u_load_addr), .load_data(u_load_data),
        .start(u_start), .sat_en(u_sat_en), .busy(u_busy), .done(u_done),
        .out_valid(u_out_valid), .out_ready(u_out_ready), .out_data(u_out_data),
        .out_row(u_out_row), .out_col(u_out_col), .ovf(u_ovf), .state_dbg(u_state_dbg)
    );

    vmm_stream_engine #(.L(2), .M(2), .N(3), .DW(4), .ACC_W(8), .SIGNED(1)) s_dut (
        .vmm_clk(vmm_clk), .rst_(rst_),
        .load_en(s_load_en), .load_sel(s_load_sel), .load_addr(s_load_addr), .load_data(s_load_data),
        .start(s_start), .sat_en(s_sat_en), .busy(s_busy), .done(s_done),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_row(s_out_row), .out_col(s_out_col), .ovf(s_ovf), .state_dbg(s_state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int r, input int c, input logic [7:0] d);
        return {r[1:0], c[1:0], d};
    endfunction

    task automatic tick();
        @(posedge vmm_clk);
        #1;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge vmm_clk) begin
        if (rst_ && u_out_valid && u_out_ready) begin
            if (u_exp_q.size() == 0) begin
                check("u_out_unexpected", {20'd0, 1'b0, u_out_row, 1'b0, u_out_col, u_out_data}, 32'hFFFF_FFFF);
            end else begin
                check("u_out", {20'd0, 1'b0, u_out_row, 1'b0, u_out_col, u_out_data}, {20'd0, u_exp_q.pop_front()});
            end
        end
    end

    always @(negedge vmm_clk) begin
        if (rst_ && s_out_valid && s_out_ready) begin
            if (s_exp_q.size() == 0) begin
                check("s_out_unexpected", {20'd0, 1'b0, s_out_row, s_out_col, s_out_data}, 32'hFFFF_FFFF);
            end else begin
                check("s_out", {20'd0, 1'b0, s_out_row, s_out_col, s_out_data}, {20'd0, s_exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic u_load(input logic sel, input int addr, input logic [3:0] data);
        u_load_en   = 1'b1;
        u_load_sel  = sel;
        u_load_addr = 2'(addr);
        u_load_data = data;
        tick();
        u_load_en   = 1'b0;
    endtask

    task automatic s_load(input logic sel, input int addr, input logic [3:0] data);
        s_load_en   = 1'b1;
        s_load_sel  = sel;
        s_load_addr = 3'(addr);
        s_load_data = data;
        tick();
        s_load_en   = 1'b0;
    endtask

    // Element e of a matrix sits in nibble e (element 0 in the low nibble).
    task automatic u_load_mats(input logic [15:0] a, input logic [15:0] b);
        for (int e = 0; e < 4; e++) u_load(1'b0, e, a[4*e +: 4]);
        for (int e = 0; e < 4; e++) u_load(1'b1, e, b[4*e +: 4]);
    endtask

    task automatic s_load_mats(input logic [15:0] a, input logic [23:0] b);
        for (int e = 0; e < 4; e++) s_load(1'b0, e, a[4*e +: 4]);
        for (int e = 0; e < 6; e++) s_load(1'b1, e, b[4*e +: 4]);
    endtask

    task automatic u_push4(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
        u_exp_q.push_back(mk(0, 0, d0));
        u_exp_q.push_back(mk(0, 1, d1));
        u_exp_q.push_back(mk(1, 0, d2));
        u_exp_q.push_back(mk(1, 1, d3));
    endtask

    task automatic s_push6(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5);
        s_exp_q.push_back(mk(0, 0, d0));
        s_exp_q.push_back(mk(0, 1, d1));
        s_exp_q.push_back(mk(0, 2, d2));
        s_exp_q.push_back(mk(1, 0, d3));
        s_exp_q.push_back(mk(1, 1, d4));
        s_exp_q.push_back(mk(1, 2, d5));
    endtask

    // bp: cycles to stall the first element (its value must be 19 at (0,0));
    // poke: cycle at which load_en and start are pulsed while busy (0 = none).
    task automatic u_run(input logic sat, input int bp, input int poke, input int exp_done, input logic exp_ovf);
        int cyc, hold, busy_cnt;
        u_out_ready = (bp == 0);
        u_sat_en    = sat;
        u_start     = 1'b1;
        tick();
        u_start  = 1'b0;
        cyc      = 1;
        hold     = 0;
        busy_cnt = 0;
        check("u_ovf_cleared_at_start", u_ovf, 0);
        while (!u_done && cyc < 400) begin
            if (u_busy) busy_cnt++;
            if (poke != 0 && cyc == poke) begin
                u_load_en = 1'b1; u_load_sel = 1'b0; u_load_addr = 2'd0; u_load_data = 4'd9;
                u_start   = 1'b1;
            end else if (cyc == poke + 1) begin
                u_load_en = 1'b0;
                u_start   = 1'b0;
            end
            if (bp > 0 && u_out_valid && !u_out_ready) begin
                if (hold < bp) begin
                    check("u_bp_data", u_out_data, 19);
                    check("u_bp_row", u_out_row, 0);
                    check("u_bp_col", u_out_col, 0);
                    hold++;
                end else begin
                    u_out_ready = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        check("u_done_cycle", cyc, exp_done);
        check("u_busy_cycles", busy_cnt, exp_done - 1);
        tick();
        check("u_done_single_pulse", u_done, 0);
        check("u_busy_after_done", u_busy, 0);
        check("u_ovf_after_done", u_ovf, exp_ovf);
        u_out_ready = 1'b1;
    endtask

    task automatic s_run(input logic sat, input logic exp_ovf);
        int cyc;
        s_sat_en = sat;
        s_start  = 1'b1;
        tick();
        s_start = 1'b0;
        cyc     = 1;
        while (!s_done && cyc < 400) begin
            tick();
            cyc++;
        end
        check("s_done_cycle", cyc, 25);
        tick();
        check("s_ovf_after_done", s_ovf, exp_ovf);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int done_cnt;
        u_load_en = 0; u_load_sel = 0; u_load_addr = 0; u_load_data = 0;
        u_start = 0; u_sat_en = 0; u_out_ready = 1;
        s_load_en = 0; s_load_sel = 0; s_load_addr = 0; s_load_data = 0;
        s_start = 0; s_sat_en = 0; s_out_ready = 1;

        tick();
        tick();
        check("rst_out_valid", u_out_valid, 0);
        check("rst_busy", u_busy, 0);
        check("rst_done", u_done, 0);
        check("rst_ovf", u_ovf, 0);
        check("rst_out_data", u_out_data, 0);
        check("rst_s_out_valid", s_out_valid, 0);
        rst_ = 1'b1;
        tick();

        u_load_mats(16'h4321, 16'h8765);
        u_push4(8'd19, 8'd22, 8'd43, 8'd50);
        u_run(1'b0, 0, 0, 17, 1'b0);

        u_push4(8'd19, 8'd22, 8'd43, 8'd50);
        u_run(1'b0, 5, 0, 22, 1'b0);

        u_push4(8'd19, 8'd22, 8'd43, 8'd50);
        u_run(1'b0, 0, 2, 17, 1'b0);
        u_push4(8'd19, 8'd22, 8'd43, 8'd50);
        u_run(1'b0, 0, 0, 17, 1'b0);

        u_load_mats(16'hFFFF, 16'hFFFF);
        u_push4(8'd255, 8'd255, 8'd255, 8'd255);
        u_run(1'b1, 0, 0, 17, 1'b1);
        u_push4(8'd194, 8'd194, 8'd194, 8'd194);
        u_run(1'b0, 0, 0, 17, 1'b1);

        u_load_mats(16'h1001, 16'h1001);
        u_push4(8'd1, 8'd0, 8'd0, 8'd1);
        u_run(1'b0, 0, 0, 17, 1'b0);

        // Abort during EMIT of element (0,1), then rerun from retained operands.
        u_load_mats(16'h4321, 16'h8765);
        u_exp_q.push_back(mk(0, 0, 8'd19));
        u_out_ready = 1'b1;
        u_start     = 1'b1;
        tick();
        u_start = 1'b0;
        repeat (7) tick();
        check("abort_pre_valid", u_out_valid, 1);
        check("abort_pre_col", u_out_col, 1);
        rst_ = 1'b0;
        #1;
        check("abort_out_valid", u_out_valid, 0);
        check("abort_busy", u_busy, 0);
        tick();
        rst_ = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (u_done) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);
        u_push4(8'd19, 8'd22, 8'd43, 8'd50);
        u_run(1'b0, 0, 0, 17, 1'b0);

        // Signed instance: A=[[-8,-8],[7,7]], B columns [-8,7],[7,7],[-8,-8].
        s_load_mats(16'h7788, 24'h877878);
        s_push6(8'h08, 8'h90, 8'h7F, 8'hF9, 8'h62, 8'h90);
        s_run(1'b1, 1'b1);
        for (int e = 4; e < 8; e++) s_load(1'b0, e, 4'd0);
        for (int e = 6; e < 8; e++) s_load(1'b1, e, 4'd0);
        s_push6(8'h08, 8'h90, 8'h80, 8'hF9, 8'h62, 8'h90);
        s_run(1'b0, 1'b1);

        repeat (3) tick();
        check("u_queue_drained", u_exp_q.size(), 0);
        check("s_queue_drained", s_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vmm_stream_engine.md
Name: vmm_stream_engine

Overview:
Parametrised successor to the fixed-size VMM datapath/control pair. It computes C = A x B for an L x M by M x N matrix product. A and B are written through a load port. Each C element is streamed out over a valid/ready interface as soon as it is complete, so no C array is stored. It adds signed/unsigned arithmetic, saturating or wrapping accumulation, a sticky overflow flag, and a start/busy/done handshake for a host sequencer.

Parameters:
L, 4, rows of A and C
M, 4, columns of A / rows of B (inner dimension, MAC length)
N, 4, columns of B and C
DW, 4, element width of A and B
ACC_W, 12, accumulator and out_data width (must be >= 2*DW)
SIGNED, 0, 1 = A, B, products and accumulator are two's complement; 0 = unsigned

Ports:
vmm_clk  in  1  clock; all state updates on rising edge
rst_  in  1  asynchronous active-low reset
load_en  in  1  write one element of A or B this cycle
load_sel  in  1  0 = A, 1 = B
load_addr  in  clog2(max(L*M,M*N))  row-major flat index (A: r*M+c, B: r*N+c)
load_data  in  DW  element value
start  in  1  begin a multiplication
sat_en  in  1  1 = saturate accumulator, 0 = wrap; sampled with start and held for the run
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last element is accepted
out_valid  out  1  out_data/out_row/out_col hold a valid C element
out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge
out_data  out  ACC_W  C[out_row][out_col]
out_row  out  clog2(L)  row index of the current element
out_col  out  clog2(N)  column index of the current element
ovf  out  1  sticky: some accumulation exceeded the ACC_W range during this run

Behaviour:
- Reset: FSM goes to IDLE; i, j, k, acc and all outputs are 0. A/B storage is not reset and keeps its contents. A reset asserted mid-run aborts the run: no done pulse, out_valid drops immediately.
- States: IDLE, CLR, MAC, EMIT, DONE.
- IDLE: busy=0. load_en writes A or B. Addresses >= L*M (A) or >= M*N (B) are ignored. start=1 latches sat_en, clears ovf, clears i and j, and moves to CLR. If start and load_en are both high, the load completes and the run uses the new value.
- CLR (1 cycle): acc <= 0, k <= 0, then MAC.
- MAC (exactly M cycles): acc <= f(acc + ext(A[i][k]*B[k][j])) and k increments each cycle. The product is 2*DW bits, sign- or zero-extended to ACC_W according to SIGNED. Moves to EMIT after k = M-1.
- Arithmetic: each sum is computed one bit wider than ACC_W.
  - If the sum is outside the ACC_W range (unsigned 0..2^ACC_W-1; signed -2^(ACC_W-1)..2^(ACC_W-1)-1), ovf <= 1.
  - f clamps to the nearest bound when sat_en is latched 1.
  - f truncates to ACC_W bits when sat_en is latched 0.
- EMIT: out_valid=1 with out_data=acc, out_row=i, out_col=j. These outputs stay stable until accepted; under backpressure the FSM holds with no timeout.
- On acceptance:
  - If j < N-1: j++ and go to CLR.
  - Else if i < L-1: j=0, i++ and go to CLR.
  - Else go to DONE.
  - out_valid drops in the cycle after acceptance.
- Output order is row-major.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- While busy: start and load_en are ignored. A and B are not modified.
- Cycle count: with out_ready held high, one element takes M+2 cycles. done is high in cycle L*N*(M+2)+1 after the start edge (start edge = cycle 0).
- ovf stays valid after DONE until the next accepted start.

Test Plan:
- L=M=N=2, DW=4, ACC_W=8, SIGNED=0; A=[[1,2],[3,4]], B=[[5,6],[7,8]]; start with out_ready=1 -> outputs 19 (0,0), 22 (0,1), 43 (1,0), 50 (1,1) in that order; ovf=0; done is a single pulse at cycle 17; busy is high in cycles 1..16.
- Same config, A and B all 15:
  - sat_en=1 -> every out_data = 255, ovf=1.
  - Repeat with sat_en=0 -> every out_data = 194 (450 mod 256), ovf=1.
  - A third run with A = B = identity and sat_en=0 -> ovf clears to 0 at start.
- SIGNED=1, DW=4, ACC_W=8, M=2; A row [-8,-8], B column [-8,7] -> C = 64 - 56 = 8; A row [7,7], B column [7,7] -> 98; with sat_en=1, A row [-8,-8], B column [-8,-8] -> 127, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles on the first element -> out_valid stays 1 and out_data/out_row/out_col are unchanged; no MAC progress; the first element is accepted on the edge where out_ready rises; done is delayed by exactly 5 cycles.
- Busy protection: pulse load_en (A[0]=9) and start during MAC -> results are unchanged and no restart occurs. Address out of range in IDLE (load_addr=4 with L*M=4) -> no write, verified by the next run's results.
- Assert rst_ low during EMIT of element (0,1) -> out_valid=0, busy=0, done never pulses. A fresh start then reproduces 19, 22, 43, 50 from the retained A and B.
